// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared state encoding and default constants for the tug-of-war controller
package tug_pkg;

  typedef enum logic [2:0] {
    ROUND_RST,
    PLAY,
    POINT,
    GAP,
    OVER
  } tug_state_t;

  localparam int DEF_SCORE_W   = 3;
  localparam int DEF_WIN_SCORE = 7;
  localparam int DEF_ROUND_GAP = 4;

endpackage

// File: rtl/tug_game_ctrl_if.sv
// rtl/tug_game_ctrl_if.sv - player keys, chain edges and game status between controller and board
interface tug_game_ctrl_if
  import tug_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W
) ();

  logic               keyL;
  logic               keyR;
  logic               edgeL;
  logic               edgeR;
  logic               moveL;
  logic               moveR;
  logic               roundRST;
  logic [SCORE_W-1:0] scoreL;
  logic [SCORE_W-1:0] scoreR;
  logic               gameOver;
  logic               winner;

  // master: the game controller; slave: keys, light chain and score display
  modport master (
    input  keyL, keyR, edgeL, edgeR,
    output moveL, moveR, roundRST, scoreL, scoreR, gameOver, winner
  );

  modport slave (
    output keyL, keyR, edgeL, edgeR,
    input  moveL, moveR, roundRST, scoreL, scoreR, gameOver, winner
  );

endinterface

// File: rtl/tug_game_ctrl_key_conditioner.sv
// rtl/tug_game_ctrl_key_conditioner.sv - key_conditioner: 2-flop synchronizer plus rising-edge detect
module key_conditioner (
  input  logic Clock,
  input  logic RST,
  input  logic key_raw,
  output logic press
);

  // [0],[1] synchronize the raw key; [2] remembers the previous synced level
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], key_raw};
  end

  always_ff @(posedge Clock) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign press = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tug_game_ctrl.sv
// rtl/tug_game_ctrl.sv - round/score FSM for the tug-of-war game; INPUT_COND_EN adds key conditioning
module tug_game_ctrl
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int WIN_SCORE  = DEF_WIN_SCORE,
  parameter int ROUND_GAP  = DEF_ROUND_GAP
) (
  input logic            Clock,
  input logic            RST,
  tug_game_ctrl_if.master bus
);

  localparam int GAP_W = (ROUND_GAP > 1) ? $clog2(ROUND_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(ROUND_GAP - 1);
  localparam logic [SCORE_W-1:0] WIN_Q    = SCORE_W'(WIN_SCORE);

  if (NUM_LIGHTS < 1 || ROUND_GAP < 1 || WIN_SCORE < 1 || WIN_SCORE > (1 << SCORE_W) - 1) begin : g_bad_cfg
    $error("tug_game_ctrl: invalid parameter combination");
  end

  tug_state_t         state_q, state_d;
  logic               moveL_q, moveL_d;
  logic               moveR_q, moveR_d;
  logic               roundRST_q, roundRST_d;
  logic               gameOver_q, gameOver_d;
  logic               winner_q, winner_d;
  logic               rwin_q, rwin_d;
  logic [SCORE_W-1:0] scoreL_q, scoreL_d;
  logic [SCORE_W-1:0] scoreR_q, scoreR_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic               press_l, press_r;
  logic               edge_hit;
  logic               point_final;
  logic [SCORE_W-1:0] new_score;

`ifdef INPUT_COND_EN
  key_conditioner u_cond_l (.Clock(Clock), .RST(RST), .key_raw(bus.keyL), .press(press_l));
  key_conditioner u_cond_r (.Clock(Clock), .RST(RST), .key_raw(bus.keyR), .press(press_r));
`else
  assign press_l = bus.keyL;
  assign press_r = bus.keyR;
`endif

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == WIN_Q) ? s : s + 1'b1;
  endfunction

  // both edges lit at once is a glitch on the chain, not a round win
  always_comb begin
    edge_hit    = bus.edgeL ^ bus.edgeR;
    new_score   = rwin_q ? sat_inc(scoreR_q) : sat_inc(scoreL_q);
    point_final = (new_score == WIN_Q);
  end

  always_ff @(posedge Clock) begin
    if (RST) begin
      state_q <= ROUND_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ROUND_RST: state_d = PLAY;
      PLAY:      if (edge_hit) state_d = POINT;
      POINT:     state_d = point_final ? OVER : GAP;
      GAP:       if (gap_cnt_q == '0) state_d = ROUND_RST;
      OVER:      state_d = OVER;
      default:   state_d = ROUND_RST;
    endcase
  end

  // registered outputs are computed from the upcoming state so they line up with it
  always_comb begin
    moveL_d    = 1'b0;
    moveR_d    = 1'b0;
    roundRST_d = (state_d == ROUND_RST);
    gameOver_d = (state_d == OVER);
    winner_d   = winner_q;
    rwin_d     = rwin_q;
    scoreL_d   = scoreL_q;
    scoreR_d   = scoreR_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      PLAY: begin
        if (edge_hit) begin
          rwin_d = bus.edgeR;
        end else begin
          moveL_d = press_l & ~press_r;
          moveR_d = press_r & ~press_l;
        end
      end
      POINT: begin
        if (rwin_q) scoreR_d = new_score;
        else        scoreL_d = new_score;
        if (point_final) winner_d = rwin_q;
        gap_cnt_d = GAP_LOAD;
      end
      GAP: begin
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (RST) begin
      moveL_q    <= 1'b0;
      moveR_q    <= 1'b0;
      roundRST_q <= 1'b1;
      gameOver_q <= 1'b0;
      winner_q   <= 1'b0;
      rwin_q     <= 1'b0;
      scoreL_q   <= '0;
      scoreR_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      moveL_q    <= moveL_d;
      moveR_q    <= moveR_d;
      roundRST_q <= roundRST_d;
      gameOver_q <= gameOver_d;
      winner_q   <= winner_d;
      rwin_q     <= rwin_d;
      scoreL_q   <= scoreL_d;
      scoreR_q   <= scoreR_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.moveL    = moveL_q;
  assign bus.moveR    = moveR_q;
  assign bus.roundRST = roundRST_q;
  assign bus.gameOver = gameOver_q;
  assign bus.winner   = winner_q;
  assign bus.scoreL   = scoreL_q;
  assign bus.scoreR   = scoreR_q;

endmodule

// File: doc/tug_game_ctrl.md
# tug_game_ctrl

Round and score controller for the two-player tug-of-war LED game on the DE1-SoC. It sits between the player keys and the LED light chain, which is made of one center cell plus normal cells. It arbitrates the two players' presses into single-cycle move pulses. It also detects when the light reaches an end of the chain, keeps per-player scores, resets the chain between rounds, and declares the game winner.

## Interface
- NUM_LIGHTS, 9, cells in the chain (informational; sizes nothing internally)
- SCORE_W, 3, width of each score counter
- WIN_SCORE, 7, score that ends the game; must be ≤ 2^SCORE_W − 1
- ROUND_GAP, 4, idle cycles between a point and the next round reset; must be ≥ 1
- Clock  in  1  system clock, 50 MHz
- RST  in  1  reset, synchronous, active-high
- keyL  in  1  left player key (press pulse, or raw key when INPUT_COND_EN)
- keyR  in  1  right player key
- edgeL  in  1  leftmost chain cell lit
- edgeR  in  1  rightmost chain cell lit
- moveL  out  1  one-cycle pulse to chain L input
- moveR  out  1  one-cycle pulse to chain R input
- roundRST  out  1  chain reset; the center cell is lit when it is applied
- scoreL  out  SCORE_W  left player score
- scoreR  out  SCORE_W  right player score
- gameOver  out  1  game finished
- winner  out  1  0 = left, 1 = right; valid only while gameOver = 1

## Operation
- Reset values:
  - state ROUND_RST; roundRST = 1
  - moveL, moveR = 0
  - scoreL, scoreR = 0
  - gameOver = 0, winner = 0
- All outputs are registered.
- FSM states: ROUND_RST, PLAY, POINT, GAP, OVER.
- ROUND_RST:
  - roundRST = 1 for exactly one cycle.
  - Next state is PLAY.
- PLAY, move arbitration (press pL/pR means the conditioned key pulse):
  - pL only: moveL pulses next cycle.
  - pR only: moveR pulses next cycle.
  - pL and pR in the same cycle: both cancel; no move.
- PLAY, end detection:
  - edgeL = 1 and edgeR = 0: left player wins the round; go to POINT.
  - edgeR = 1 and edgeL = 0: right player wins the round; go to POINT.
  - edgeL and edgeR both 1: illegal; ignored, stay in PLAY.
  - When an edge is detected, any key press in the same cycle is discarded.
- POINT:
  - Increment the round winner's score by 1, saturating at WIN_SCORE.
  - If the new score equals WIN_SCORE, go to OVER and set winner. Otherwise go to GAP.
- GAP:
  - Down-counter loaded with ROUND_GAP − 1; lasts ROUND_GAP cycles.
  - Then go to ROUND_RST.
- OVER:
  - gameOver = 1; scores and winner hold.
  - moveL, moveR, roundRST held at 0; keys and edges ignored.
  - Leave only via RST.
- Keys are ignored in every state except PLAY. No press is queued.
- RST has priority over everything at any point. It restarts the game in the same cycle, including mid-GAP or mid-POINT, and clears scores.

## Timing
- Press to move: key pulse sampled in cycle N (state PLAY) → move pulse during N+1, width 1.
- Edge to point: edge sampled in cycle N → POINT at N+1 → score visible at N+2.
- Point to next round: GAP spans N+2 to N+1+ROUND_GAP; ROUND_RST at N+2+ROUND_GAP; PLAY at N+3+ROUND_GAP. With the default ROUND_GAP = 4, PLAY resumes at N+7.
- Game end: gameOver and winner rise at N+2, in the same cycle the final score becomes visible.
- After RST deasserts: ROUND_RST for 1 cycle, then PLAY.

## Configuration
- INPUT_COND_EN defined:
  - Each raw key passes through a 2-flop synchronizer plus a rising-edge detector.
  - A held key yields exactly one press.
  - Raw rise to move pulse takes 3 cycles.
  - Synchronizer flops reset to 0.
- INPUT_COND_EN undefined:
  - keyL/keyR are used directly as press pulses.
  - A key held high yields a move attempt every PLAY cycle.
  - Latency stays at 1 cycle.

## Structure
- Package tug_pkg holds:
  - the state enum tug_state_t
  - the default constants DEF_SCORE_W, DEF_WIN_SCORE, DEF_ROUND_GAP
- Sub-module key_conditioner (synchronizer + edge detect): instantiated twice, only under INPUT_COND_EN.
- Top level holds the FSM, gap counter, score registers and move registers.

## Test plan
- RST for 1 cycle → roundRST = 1 the next cycle; scores 0, gameOver 0; PLAY the cycle after.
- PLAY, keyL pulse at cycle N → moveL = 1 only at N+1. keyL and keyR together → no move.
- PLAY, edgeL = 1 at N → scoreL = 1 at N+2; roundRST = 1 at N+6; keys ignored from N+1 to N+6.
- Right player wins 7 rounds → scoreR = 7, gameOver = 1, winner = 1. Further keys and edges leave outputs unchanged.
- Assert RST during GAP with scoreL = 3 → next cycle scores 0 and roundRST = 1.
- With INPUT_COND_EN, hold keyR for 10 cycles → exactly one moveR, 3 cycles after the rise.
